// File: rtl/bp_fe_pred_update_sched.sv
// bp_fe_pred_update_sched
//   Arbitrates predictor (BTB/BHT) training updates onto a single write port.
//   Mispredict redirects arrive without backpressure and sit in a one-entry
//   buffer. A newer redirect overwrites an ungranted one, and each overwrite
//   is counted. Correct-prediction "attaboy" updates are queued in a small
//   FIFO. Redirects normally win arbitration. After starve_limit_p
//   consecutive redirect grants, a waiting attaboy is forced through.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   init_done_i               predictor tables initialised (level)
//   ready_o                   scheduler is in RUN
//   redirect_*_i              mispredict update (valid only, no ready)
//   attaboy_*                 correct-prediction update (valid/ready)
//   upd_*                     predictor write port (valid/yumi); every upd_*
//                             output is derived from registers only
//   drain_i, drain_done_o     drain request pulse / one-cycle completion
//   drop_cnt_o                saturating count of overwritten redirects
module bp_fe_pred_update_sched #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 64,
  parameter int fifo_els_p                  = 4,
  parameter int starve_limit_p              = 3
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,

  input  logic                                   init_done_i,
  output logic                                   ready_o,

  input  logic                                   redirect_v_i,
  input  logic [vaddr_width_p-1:0]               redirect_pc_i,
  input  logic [branch_metadata_fwd_width_p-1:0] redirect_metadata_i,
  input  logic                                   redirect_taken_i,
  input  logic                                   redirect_nonbr_i,

  input  logic                                   attaboy_v_i,
  output logic                                   attaboy_ready_o,
  input  logic [vaddr_width_p-1:0]               attaboy_pc_i,
  input  logic [branch_metadata_fwd_width_p-1:0] attaboy_metadata_i,
  input  logic                                   attaboy_taken_i,

  output logic                                   upd_v_o,
  input  logic                                   upd_yumi_i,
  output logic [vaddr_width_p-1:0]               upd_pc_o,
  output logic [branch_metadata_fwd_width_p-1:0] upd_metadata_o,
  output logic                                   upd_taken_o,
  output logic                                   upd_nonbr_o,
  output logic                                   upd_redirect_o,

  input  logic                                   drain_i,
  output logic                                   drain_done_o,
  output logic [7:0]                             drop_cnt_o
);

  localparam int ptr_w_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int starve_w_lp = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;
  localparam int entry_w_lp  = vaddr_width_p + branch_metadata_fwd_width_p + 1;

  localparam logic [ptr_w_lp:0]      ptr_one_lp    = (ptr_w_lp + 1)'(1);
  localparam logic [starve_w_lp-1:0] starve_one_lp = starve_w_lp'(1);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e state;

  // One-entry redirect buffer
  logic                                   rbuf_v;
  logic [vaddr_width_p-1:0]               rbuf_pc;
  logic [branch_metadata_fwd_width_p-1:0] rbuf_md;
  logic                                   rbuf_taken;
  logic                                   rbuf_nonbr;

  // Attaboy FIFO. The pointers carry an extra wrap bit for the full/empty test.
  logic [entry_w_lp-1:0] fifo_mem [fifo_els_p];
  logic [ptr_w_lp:0]     wr_ptr;
  logic [ptr_w_lp:0]     rd_ptr;
  logic [entry_w_lp-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;

  logic [starve_w_lp-1:0] starve_cnt;
  logic [7:0]             drop_cnt;

  logic active;
  logic flush;
  logic sel_fifo;
  logic grant;
  logic rbuf_grant;
  logic fifo_grant;
  logic enq;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[ptr_w_lp] != rd_ptr[ptr_w_lp])
                   && (wr_ptr[ptr_w_lp-1:0] == rd_ptr[ptr_w_lp-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[ptr_w_lp-1:0]];

  assign active = (state != S_INIT);
  // Losing init_done_i while active drops every pending update.
  assign flush  = active & ~init_done_i;

  // The FIFO head is also chosen when the redirect buffer is empty.
  // Otherwise the buffer would block attaboys with nothing to send.
  assign sel_fifo   = ~fifo_empty & (~rbuf_v | (starve_cnt == starve_max_lp));
  assign grant      = upd_v_o & upd_yumi_i;
  assign rbuf_grant = grant & ~sel_fifo;
  assign fifo_grant = grant &  sel_fifo;
  assign enq        = attaboy_v_i & attaboy_ready_o;

  assign ready_o         = (state == S_RUN);
  assign attaboy_ready_o = (state == S_RUN) & ~fifo_full;
  assign drain_done_o    = (state == S_DRAIN) & ~rbuf_v & fifo_empty;
  assign drop_cnt_o      = drop_cnt;

  assign upd_v_o        = rbuf_v | ~fifo_empty;
  assign upd_redirect_o = rbuf_v & ~sel_fifo;
  assign upd_pc_o       = sel_fifo ? fifo_head[entry_w_lp-1 -: vaddr_width_p] : rbuf_pc;
  assign upd_metadata_o = sel_fifo ? fifo_head[branch_metadata_fwd_width_p:1] : rbuf_md;
  assign upd_taken_o    = sel_fifo ? fifo_head[0] : rbuf_taken;
  assign upd_nonbr_o    = sel_fifo ? 1'b0 : rbuf_nonbr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= S_INIT;
      rbuf_v     <= 1'b0;
      rbuf_pc    <= '0;
      rbuf_md    <= '0;
      rbuf_taken <= 1'b0;
      rbuf_nonbr <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      unique case (state)
        S_INIT:  if (init_done_i) state <= S_RUN;
        S_RUN:   if (!init_done_i) state <= S_INIT;
                 else if (drain_i) state <= S_DRAIN;
        S_DRAIN: if (!init_done_i) state <= S_INIT;
                 else if (drain_done_o) state <= S_RUN;
        default: state <= S_INIT;
      endcase

      if (flush) begin
        rbuf_v     <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        starve_cnt <= '0;
      end else begin
        // A load in the cycle the buffer is granted replaces it cleanly.
        // Otherwise a valid buffer is overwritten, and the loss is counted.
        if (active && redirect_v_i) begin
          rbuf_v     <= 1'b1;
          rbuf_pc    <= redirect_pc_i;
          rbuf_md    <= redirect_metadata_i;
          rbuf_taken <= redirect_taken_i;
          rbuf_nonbr <= redirect_nonbr_i;
          if (rbuf_v && !rbuf_grant && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
        end else if (rbuf_grant) begin
          rbuf_v <= 1'b0;
        end

        if (enq)        wr_ptr <= wr_ptr + ptr_one_lp;
        if (fifo_grant) rd_ptr <= rd_ptr + ptr_one_lp;

        // The count cannot pass the limit. At the limit, a non-empty FIFO wins.
        if (rbuf_grant && !fifo_empty)
          starve_cnt <= starve_cnt + starve_one_lp;
        else if (fifo_grant || fifo_empty)
          starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      fifo_mem[wr_ptr[ptr_w_lp-1:0]] <= {attaboy_pc_i, attaboy_metadata_i, attaboy_taken_i};
  end

endmodule

// File: tb/tb_bp_fe_pred_update_sched.sv
module tb_bp_fe_pred_update_sched;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        init_done_i;
  logic        ready_o;
  logic        redirect_v_i;
  logic [38:0] redirect_pc_i;
  logic [63:0] redirect_metadata_i;
  logic        redirect_taken_i;
  logic        redirect_nonbr_i;
  logic        attaboy_v_i;
  logic        attaboy_ready_o;
  logic [38:0] attaboy_pc_i;
  logic [63:0] attaboy_metadata_i;
  logic        attaboy_taken_i;
  logic        upd_v_o;
  logic        upd_yumi_i;
  logic [38:0] upd_pc_o;
  logic [63:0] upd_metadata_o;
  logic        upd_taken_o;
  logic        upd_nonbr_o;
  logic        upd_redirect_o;
  logic        drain_i;
  logic        drain_done_o;
  logic [7:0]  drop_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_fe_pred_update_sched #(
    .vaddr_width_p(39),
    .branch_metadata_fwd_width_p(64),
    .fifo_els_p(4),
    .starve_limit_p(3)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n_i),
    .init_done_i(init_done_i),
    .ready_o(ready_o),
    .redirect_v_i(redirect_v_i),
    .redirect_pc_i(redirect_pc_i),
    .redirect_metadata_i(redirect_metadata_i),
    .redirect_taken_i(redirect_taken_i),
    .redirect_nonbr_i(redirect_nonbr_i),
    .attaboy_v_i(attaboy_v_i),
    .attaboy_ready_o(attaboy_ready_o),
    .attaboy_pc_i(attaboy_pc_i),
    .attaboy_metadata_i(attaboy_metadata_i),
    .attaboy_taken_i(attaboy_taken_i),
    .upd_v_o(upd_v_o),
    .upd_yumi_i(upd_yumi_i),
    .upd_pc_o(upd_pc_o),
    .upd_metadata_o(upd_metadata_o),
    .upd_taken_o(upd_taken_o),
    .upd_nonbr_o(upd_nonbr_o),
    .upd_redirect_o(upd_redirect_o),
    .drain_i(drain_i),
    .drain_done_o(drain_done_o),
    .drop_cnt_o(drop_cnt_o)
  );

  // Inputs for one cycle, and the outputs expected during that cycle.
  // Outputs depend only on DUT state, so they reflect the earlier rows.
  typedef struct {
    int rv; int rpc; int av; int apc; int yu; int dr; int in;
    int uv; int pc;  int rd; int ar;  int ry; int dd; int dp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int rv, input int rpc, input int av, input int apc,
                     input int yu, input int dr, input int in,
                     input int uv, input int pc, input int rd, input int ar,
                     input int ry, input int dd, input int dp);
    vec_t v;
    v = '{rv, rpc, av, apc, yu, dr, in, uv, pc, rd, ar, ry, dd, dp};
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    redirect_v_i        = 1'b0;
    redirect_pc_i       = '0;
    redirect_metadata_i = '0;
    attaboy_v_i         = 1'b0;
    attaboy_pc_i        = '0;
    attaboy_metadata_i  = '0;
    upd_yumi_i          = 1'b0;
    drain_i             = 1'b0;
  endtask

  initial begin
    // Redirects always carry taken=1 and nonbr=1, and attaboys carry taken=0.
    // upd_taken_o and upd_nonbr_o therefore both equal upd_redirect_o.
    redirect_taken_i = 1'b1;
    redirect_nonbr_i = 1'b1;
    attaboy_taken_i  = 1'b0;
    idle_inputs();
    init_done_i = 1'b0;
    reset_n_i   = 1'b0;

    //            rv  rpc   av  apc   yu dr in | uv  pc    rd ar ry dd dp
    // FIFO fill to full, 5th refused, drain in order
    add(0, 0,     1, 'h11, 0, 0, 1,   0, 0,     0, 1, 1, 0, 0);
    add(0, 0,     1, 'h12, 0, 0, 1,   1, 'h11,  0, 1, 1, 0, 0);
    add(0, 0,     1, 'h13, 0, 0, 1,   1, 'h11,  0, 1, 1, 0, 0);
    add(0, 0,     1, 'h14, 0, 0, 1,   1, 'h11,  0, 1, 1, 0, 0);
    add(0, 0,     1, 'h15, 0, 0, 1,   1, 'h11,  0, 0, 1, 0, 0);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h11,  0, 0, 1, 0, 0);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h12,  0, 1, 1, 0, 0);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h13,  0, 1, 1, 0, 0);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h14,  0, 1, 1, 0, 0);
    add(0, 0,     0, 0,    0, 0, 1,   0, 0,     0, 1, 1, 0, 0);
    // Three back-to-back redirects, no yumi: last survives, two drops
    add(1, 'h21,  0, 0,    0, 0, 1,   0, 0,     0, 1, 1, 0, 0);
    add(1, 'h22,  0, 0,    0, 0, 1,   1, 'h21,  1, 1, 1, 0, 0);
    add(1, 'h23,  0, 0,    0, 0, 1,   1, 'h22,  1, 1, 1, 0, 1);
    add(0, 0,     0, 0,    0, 0, 1,   1, 'h23,  1, 1, 1, 0, 2);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h23,  1, 1, 1, 0, 2);
    add(0, 0,     0, 0,    1, 0, 1,   0, 0,     0, 1, 1, 0, 2);
    // Starvation: R,R,R then the waiting attaboy
    add(0, 0,     1, 'h31, 0, 0, 1,   0, 0,     0, 1, 1, 0, 2);
    add(1, 'h41,  0, 0,    0, 0, 1,   1, 'h31,  0, 1, 1, 0, 2);
    add(1, 'h42,  0, 0,    1, 0, 1,   1, 'h41,  1, 1, 1, 0, 2);
    add(1, 'h43,  0, 0,    1, 0, 1,   1, 'h42,  1, 1, 1, 0, 2);
    add(1, 'h44,  0, 0,    1, 0, 1,   1, 'h43,  1, 1, 1, 0, 2);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h31,  0, 1, 1, 0, 2);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h44,  1, 1, 1, 0, 2);
    add(0, 0,     0, 0,    0, 0, 1,   0, 0,     0, 1, 1, 0, 2);
    // Drain with two attaboys and one redirect pending
    add(0, 0,     1, 'h51, 0, 0, 1,   0, 0,     0, 1, 1, 0, 2);
    add(0, 0,     1, 'h52, 0, 0, 1,   1, 'h51,  0, 1, 1, 0, 2);
    add(1, 'h61,  0, 0,    0, 0, 1,   1, 'h51,  0, 1, 1, 0, 2);
    add(0, 0,     0, 0,    1, 1, 1,   1, 'h61,  1, 1, 1, 0, 2);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h51,  0, 0, 0, 0, 2);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h52,  0, 0, 0, 0, 2);
    add(0, 0,     0, 0,    0, 0, 1,   0, 0,     0, 0, 0, 1, 2);
    add(0, 0,     0, 0,    0, 0, 1,   0, 0,     0, 1, 1, 0, 2);
    // Empty drain; a redirect is still accepted while draining
    add(0, 0,     0, 0,    0, 1, 1,   0, 0,     0, 1, 1, 0, 2);
    add(1, 'h71,  0, 0,    0, 0, 1,   0, 0,     0, 0, 0, 1, 2);
    add(0, 0,     0, 0,    0, 0, 1,   1, 'h71,  1, 1, 1, 0, 2);
    add(0, 0,     0, 0,    1, 0, 1,   1, 'h71,  1, 1, 1, 0, 2);
    add(0, 0,     0, 0,    0, 0, 1,   0, 0,     0, 1, 1, 0, 2);
    // Losing init_done_i flushes pending work but keeps drop count
    add(1, 'h82,  1, 'h81, 0, 0, 1,   0, 0,     0, 1, 1, 0, 2);
    add(0, 0,     0, 0,    0, 0, 0,   1, 'h82,  1, 1, 1, 0, 2);
    add(0, 0,     0, 0,    0, 0, 1,   0, 0,     0, 0, 0, 0, 2);
    add(0, 0,     0, 0,    0, 0, 1,   0, 0,     0, 1, 1, 0, 2);

    // Reset state
    #3;
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_attaboy_ready", 64'(attaboy_ready_o), 64'd0);
    chk("rst_upd_v", 64'(upd_v_o), 64'd0);
    chk("rst_drain_done", 64'(drain_done_o), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    chk("rst_upd_pc", 64'(upd_pc_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;

    // INIT for 10 cycles; offered updates must be ignored
    redirect_v_i  = 1'b1;
    redirect_pc_i = 39'h5;
    attaboy_v_i   = 1'b1;
    attaboy_pc_i  = 39'h6;
    for (int i = 0; i < 10; i++) begin
      chk("init_ready", 64'(ready_o), 64'd0);
      chk("init_attaboy_ready", 64'(attaboy_ready_o), 64'd0);
      chk("init_upd_v", 64'(upd_v_o), 64'd0);
      @(posedge clk); #1;
    end
    idle_inputs();
    init_done_i = 1'b1;
    chk("init_last_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    chk("run_ready", 64'(ready_o), 64'd1);
    chk("run_upd_v", 64'(upd_v_o), 64'd0);

    foreach (vecs[i]) begin
      redirect_v_i        = 1'(vecs[i].rv);
      redirect_pc_i       = 39'(vecs[i].rpc);
      redirect_metadata_i = 64'(vecs[i].rpc);
      attaboy_v_i         = 1'(vecs[i].av);
      attaboy_pc_i        = 39'(vecs[i].apc);
      attaboy_metadata_i  = 64'(vecs[i].apc);
      upd_yumi_i          = 1'(vecs[i].yu);
      drain_i             = 1'(vecs[i].dr);
      init_done_i         = 1'(vecs[i].in);
      chk($sformatf("v%0d_upd_v", i), 64'(upd_v_o), 64'(vecs[i].uv));
      chk($sformatf("v%0d_attaboy_ready", i), 64'(attaboy_ready_o), 64'(vecs[i].ar));
      chk($sformatf("v%0d_ready", i), 64'(ready_o), 64'(vecs[i].ry));
      chk($sformatf("v%0d_drain_done", i), 64'(drain_done_o), 64'(vecs[i].dd));
      chk($sformatf("v%0d_drop_cnt", i), 64'(drop_cnt_o), 64'(vecs[i].dp));
      if (vecs[i].uv != 0) begin
        chk($sformatf("v%0d_upd_pc", i), 64'(upd_pc_o), 64'(vecs[i].pc));
        chk($sformatf("v%0d_upd_md", i), upd_metadata_o, 64'(vecs[i].pc));
        chk($sformatf("v%0d_upd_redirect", i), 64'(upd_redirect_o), 64'(vecs[i].rd));
        chk($sformatf("v%0d_upd_taken", i), 64'(upd_taken_o), 64'(vecs[i].rd));
        chk($sformatf("v%0d_upd_nonbr", i), 64'(upd_nonbr_o), 64'(vecs[i].rd));
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    init_done_i = 1'b1;

    // Asynchronous reset with the FIFO holding an attaboy
    attaboy_v_i  = 1'b1;
    attaboy_pc_i = 39'h91;
    @(posedge clk); #1;
    attaboy_v_i = 1'b0;
    chk("pre_reset_upd_v", 64'(upd_v_o), 64'd1);
    chk("pre_reset_drop_cnt", 64'(drop_cnt_o), 64'd2);
    #2 reset_n_i = 1'b0;
    #1;
    chk("async_rst_upd_v", 64'(upd_v_o), 64'd0);
    chk("async_rst_ready", 64'(ready_o), 64'd0);
    chk("async_rst_attaboy_ready", 64'(attaboy_ready_o), 64'd0);
    chk("async_rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    chk("release_upd_v", 64'(upd_v_o), 64'd0);
    chk("release_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(ready_o), 64'd1);
    chk("post_rst_attaboy_ready", 64'(attaboy_ready_o), 64'd1);
    chk("post_rst_upd_v", 64'(upd_v_o), 64'd0);
    chk("post_rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    upd_yumi_i = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_upd_v_later", 64'(upd_v_o), 64'd0);
    upd_yumi_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
